fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin, packet-atomic arbiter that shares the single write port of one `fifo` instance among N requesters. Each requester presents beats with a `last` marker. Once a requester is granted, the arbiter stays locked to it until its `last` beat is accepted, so packets are never interleaved in the FIFO. It sits directly in front of the FIFO write side: it drives the FIFO's `wr`/`w_data` and consumes its `full`.

## Interface
- `B`, default 8: data word width; must match the FIFO `B`.
- `N`, default 4: number of requesters, 2..16.
- `IDW`, default 2: owner index width, equal to ceil(log2 N).
- `MAX_BURST`, default 16: maximum accepted beats per grant before forced release; 1..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester beat valid.
- `last`  in  N  per-requester end-of-packet marker, qualified by `req`.
- `data`  in  N*B  flattened beat data; requester i occupies bits [i*B+B-1 : i*B].
- `ack`  out  N  one-hot beat accepted; requester i's beat transfers on a rising edge where `req[i] & ack[i]`.
- `fifo_wr`  out  1  to FIFO `wr`.
- `fifo_w_data`  out  B  to FIFO `w_data`.
- `fifo_full`  in  1  from FIFO `full`, which is registered in the FIFO.
- `busy`  out  1  high while in the LOCKED state.
- `owner`  out  IDW  index of the current or last granted requester.
- `overrun`  out  1  one-cycle pulse on a forced release.

## Operation
- Two-state FSM: IDLE and LOCKED. Registers: `state`, `ptr` (round-robin start, IDW bits), `owner`, `cnt` (8 bits), `overrun`.
- **IDLE:**
  - `ack`=0 and `fifo_wr`=0.
  - If any `req` bit is set: select the first set index scanning ptr, ptr+1, … wrapping modulo N. Load `owner` with that index, clear `cnt`, go to LOCKED.
  - If no `req` bit is set: stay in IDLE; `ptr` is unchanged.
- **LOCKED:**
  - `fifo_wr` = `req[owner] & ~fifo_full`.
  - `fifo_w_data` = `data` slice at `owner`.
  - `ack` = one-hot(`owner`) & {N{`fifo_wr`}}.
  - On each accepted beat, `cnt` increments.
  - Normal release: an accepted beat with `last[owner]`=1 → IDLE, `ptr` ← (`owner`+1) mod N, `cnt` ← 0.
  - Forced release: an accepted beat that makes `cnt`+1 == MAX_BURST without `last` → IDLE, `ptr` ← (`owner`+1) mod N, `overrun` pulses high for 1 cycle. Later beats from that requester are arbitrated as a new grant.
  - If `last` and the MAX_BURST limit coincide on the same beat, this is a normal release with no `overrun`.
  - If `req[owner]` drops mid-packet, the arbiter stays LOCKED with no write and no timeout. Other requesters are ignored until release.
  - If `fifo_full`=1, no write occurs; `ack` stays 0 and `cnt` holds.
- `fifo_w_data` in IDLE = `data` slice at `owner` (don't-care; the FIFO ignores it because `fifo_wr`=0).
- `ptr` wraps from N-1 to 0. `owner` arithmetic is modulo N; for non-power-of-2 N, indices ≥ N are never selected.
- Signals from non-owner requesters never reach the FIFO.

## Timing
- Reset (`reset_n`=0, asynchronous): `state`=IDLE, `ptr`=0, `owner`=0, `cnt`=0, `overrun`=0. Outputs: `ack`=0, `fifo_wr`=0, `busy`=0, `owner`=0, `overrun`=0.
- Reset is released synchronously to `clk` by the system.
- Reset mid-packet drops the grant immediately. Any partially written packet stays in the FIFO; the FIFO is reset by the same `reset_n` at system level.
- Arbitration latency: `req` rising in cycle t (in IDLE) → LOCKED in t+1 → first `ack` in t+1 if the FIFO is not full.
- Throughput:
  - Back-to-back beats of one packet, 1 beat/cycle.
  - One bubble cycle (IDLE) between packets.
  - Minimum N+... cycles are not required; fairness is round-robin per packet.
- `ack`/`fifo_wr` are combinational from registered state, `req`, and `fifo_full`. There is no combinational path from `ack` back to `req`.
- `fifo_full` is a registered FIFO output, so there is no combinational loop.
- `busy` and `owner` are registered. `overrun` is registered and asserted in the cycle after the releasing beat.

## Test plan
- **Reset:** assert `reset_n`=0 mid-packet (`owner`=2, 3 beats sent) → `ack`=0, `fifo_wr`=0, `busy`=0, `owner`=0 immediately; after release with `req`=4'b0100, the grant goes to 2 from `ptr`=0.
- **Round-robin:** `req`=4'b1111, each requester sends a 2-beat packet with data 8'hi0, 8'hi1 → FIFO receives packets in order 0,1,2,3 with no interleaving; 1 idle cycle between packets; `ptr` wraps to 0.
- **Backpressure:** `owner`=1 streaming 6 beats; hold `fifo_full`=1 for 3 cycles at beat 3 → `ack` and `fifo_wr` are 0 for those cycles; FIFO contents are exactly beats 0..5 in order; `cnt` ends at 0 after `last`.
- **Requester stall:** `owner`=0 drops `req[0]` for 4 cycles mid-packet while `req[3]`=1 → `busy` stays 1, `ack[3]` never asserts, `owner` 0 resumes, then 3 is granted.
- **Overrun:** MAX_BURST=4, requester 1 sends 6 beats with no `last` → 4 acks, then `overrun`=1 for one cycle, IDLE, `ptr`=2; with only `req[1]` active, it is re-granted and the remaining 2 beats are accepted.
- **Boundary coincidence:** MAX_BURST=4, `last` on beat 4 → normal release, `overrun` stays 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one FIFO write port among N requesters.
// A grant is held until the owner's last beat is accepted or MAX_BURST beats have gone through.
module fifo_write_arbiter #(
    parameter int unsigned B         = 8,
    parameter int unsigned N         = 4,
    parameter int unsigned IDW       = 2,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     last,
    input  logic [N*B-1:0]   data,
    output logic [N-1:0]     ack,
    output logic             fifo_wr,
    output logic [B-1:0]     fifo_w_data,
    input  logic             fifo_full,
    output logic             busy,
    output logic [IDW-1:0]   owner,
    output logic             overrun
);

    localparam int unsigned CW = 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            overrun_d;

    logic [IDW-1:0]  sel;
    logic            sel_vld;
    logic [IDW-1:0]  cand;
    int unsigned     idx;
    logic [IDW-1:0]  owner_nxt;

    logic [B-1:0]    data_arr [N];

    // Unflatten the requester data bus so the owner can index it directly
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign data_arr[g] = data[g*B +: B];
    end

    assign fifo_w_data = data_arr[owner];
    assign busy        = (state_q == S_LOCKED);
    assign owner_nxt   = (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);
    assign cnt_inc     = cnt_q + CW'(1);

    // First active requester scanning ptr, ptr+1, ... modulo N
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = IDW'(idx);
            if (!sel_vld && req[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
        end
    end

    // Next-state and write-port outputs
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner;
        cnt_d     = cnt_q;
        overrun_d = 1'b0;
        fifo_wr   = 1'b0;
        ack       = '0;

        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    owner_d = sel;
                    cnt_d   = '0;
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                fifo_wr = req[owner] & ~fifo_full;
                for (int unsigned i = 0; i < N; i++) begin
                    ack[i] = fifo_wr && (owner == IDW'(i));
                end
                if (fifo_wr) begin
                    cnt_d = cnt_inc;
                    // last wins over the burst limit when both land on the same beat
                    if (last[owner]) begin
                        state_d = S_IDLE;
                        ptr_d   = owner_nxt;
                        cnt_d   = '0;
                    end else if (cnt_inc == CW'(MAX_BURST)) begin
                        state_d   = S_IDLE;
                        ptr_d     = owner_nxt;
                        cnt_d     = '0;
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner   <= '0;
            cnt_q   <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner   <= owner_d;
            cnt_q   <= cnt_d;
            overrun <= overrun_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: one instance with default MAX_BURST, one with MAX_BURST=4.
// Both share stimulus; each FIFO write port is captured into its own queue.
module tb_fifo_write_arbiter;

    localparam int B   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*B-1:0] data;
    logic           fifo_full;
    logic [B-1:0]   din [N];

    logic [N-1:0]   ack,  ack4;
    logic           fifo_wr, fifo_wr4;
    logic [B-1:0]   fifo_w_data, fifo_w_data4;
    logic           busy, busy4;
    logic [IDW-1:0] owner, owner4;
    logic           overrun, overrun4;

    logic [B-1:0] got_q[$];
    logic [B-1:0] got4_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) data[i*B +: B] = din[i];
    end

    fifo_write_arbiter #(.B(B), .N(N), .IDW(IDW), .MAX_BURST(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .last(last), .data(data),
        .ack(ack), .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data), .fifo_full(fifo_full),
        .busy(busy), .owner(owner), .overrun(overrun)
    );

    fifo_write_arbiter #(.B(B), .N(N), .IDW(IDW), .MAX_BURST(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req(req), .last(last), .data(data),
        .ack(ack4), .fifo_wr(fifo_wr4), .fifo_w_data(fifo_w_data4), .fifo_full(fifo_full),
        .busy(busy4), .owner(owner4), .overrun(overrun4)
    );

    always @(posedge clk) begin
        if (fifo_wr)  got_q.push_back(fifo_w_data);
        if (fifo_wr4) got4_q.push_back(fifo_w_data4);
    end

    function automatic logic [N-1:0] oh(input int i);
        oh = N'(1) << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req       = '0;
        last      = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) din[i] = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        got_q.delete();
        got4_q.delete();
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        clear_inputs();
        reset_n = 1'b0;
        tick();
        #1;
        obs = {busy, owner, overrun, ack, fifo_wr};
        total_cnt++;
        if (obs !== 9'b0) $display("FAIL reset_state: got %b expected %b", obs, 9'b0);
        else pass_cnt++;

        reset_n = 1'b1;
        got_q.delete();
        req     = 4'b0100;
        din[2]  = 8'h20;
        #1;
        total_cnt++;
        if (ack !== 4'b0000) $display("FAIL reset_idle_ack: got %b expected 0000", ack);
        else pass_cnt++;
        tick();
        for (int b = 0; b < 3; b++) begin
            din[2] = 8'(8'h20 + b);
            #1;
            total_cnt++;
            if ({ack, fifo_wr} !== {4'b0100, 1'b1})
                $display("FAIL reset_pre_beat%0d: got ack=%b wr=%b expected ack=0100 wr=1", b, ack, fifo_wr);
            else pass_cnt++;
            tick();
        end
        reset_n = 1'b0;
        #1;
        obs = {busy, owner, overrun, ack, fifo_wr};
        total_cnt++;
        if (obs !== 9'b0) $display("FAIL reset_midpacket: got %b expected %b", obs, 9'b0);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() !== 3) $display("FAIL reset_beats_written: got %0d expected 3", got_q.size());
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if ({busy, owner} !== {1'b1, 2'd2})
            $display("FAIL reset_regrant: got busy=%b owner=%0d expected busy=1 owner=2", busy, owner);
        else pass_cnt++;
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [B-1:0] exp, g;
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) din[i] = 8'(i * 16);
        for (int p = 0; p < N; p++) begin
            #1;
            total_cnt++;
            if ({busy, ack} !== 5'b0) $display("FAIL rr_gap%0d: got busy=%b ack=%b expected 0 0000", p, busy, ack);
            else pass_cnt++;
            tick();
            #1;
            total_cnt++;
            if ({owner, ack} !== {2'(p), oh(p)})
                $display("FAIL rr_grant%0d: got owner=%0d ack=%b expected owner=%0d ack=%b", p, owner, ack, p, oh(p));
            else pass_cnt++;
            tick();
            din[p]  = 8'(p * 16 + 1);
            last[p] = 1'b1;
            #1;
            total_cnt++;
            if ({ack, fifo_w_data} !== {oh(p), 8'(p * 16 + 1)})
                $display("FAIL rr_last%0d: got ack=%b data=%h expected ack=%b data=%h", p, ack, fifo_w_data, oh(p), 8'(p * 16 + 1));
            else pass_cnt++;
            tick();
            req[p]  = 1'b0;
            last[p] = 1'b0;
        end
        total_cnt++;
        if (got_q.size() !== 8) $display("FAIL rr_count: got %0d expected 8", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            exp = 8'((i / 2) * 16 + (i % 2));
            g   = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total_cnt++;
            if (g !== exp) $display("FAIL rr_order%0d: got %h expected %h", i, g, exp);
            else pass_cnt++;
        end
        req = 4'b1111;
        for (int i = 0; i < N; i++) din[i] = 8'(i * 16);
        tick();
        total_cnt++;
        if (owner !== 2'd0) $display("FAIL rr_wrap: got owner=%0d expected 0", owner);
        else pass_cnt++;
        req = '0;
    endtask

    task automatic test_backpressure();
        logic [B-1:0] g;
        apply_reset();
        req[1] = 1'b1;
        din[1] = 8'h50;
        tick();
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                fifo_full = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    #1;
                    total_cnt++;
                    if ({ack, fifo_wr} !== 5'b0)
                        $display("FAIL bp_full%0d: got ack=%b wr=%b expected 0000 0", c, ack, fifo_wr);
                    else pass_cnt++;
                    tick();
                end
                fifo_full = 1'b0;
            end
            din[1]  = 8'(8'h50 + k);
            last[1] = (k == 5);
            #1;
            total_cnt++;
            if ({ack, fifo_w_data} !== {4'b0010, 8'(8'h50 + k)})
                $display("FAIL bp_beat%0d: got ack=%b data=%h expected ack=0010 data=%h", k, ack, fifo_w_data, 8'(8'h50 + k));
            else pass_cnt++;
            tick();
        end
        req  = '0;
        last = '0;
        #1;
        total_cnt++;
        if ({busy, dut.cnt_q} !== 9'b0) $display("FAIL bp_release: got busy=%b cnt=%0d expected 0 0", busy, dut.cnt_q);
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() !== 6) $display("FAIL bp_count: got %0d expected 6", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total_cnt++;
            if (g !== 8'(8'h50 + i)) $display("FAIL bp_fifo%0d: got %h expected %h", i, g, 8'(8'h50 + i));
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [B-1:0] g;
        logic [B-1:0] exp [5];
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h3C};
        apply_reset();
        req     = 4'b1001;
        din[0]  = 8'hA0;
        din[3]  = 8'h3C;
        last[3] = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            din[0] = 8'(8'hA0 + k);
            #1;
            total_cnt++;
            if (ack !== 4'b0001) $display("FAIL stall_pre%0d: got ack=%b expected 0001", k, ack);
            else pass_cnt++;
            tick();
        end
        req[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            total_cnt++;
            if ({busy, owner, ack, fifo_wr} !== {1'b1, 2'd0, 4'b0000, 1'b0})
                $display("FAIL stall_hold%0d: got busy=%b owner=%0d ack=%b wr=%b expected 1 0 0000 0", c, busy, owner, ack, fifo_wr);
            else pass_cnt++;
            tick();
        end
        req[0] = 1'b1;
        for (int k = 2; k < 4; k++) begin
            din[0]  = 8'(8'hA0 + k);
            last[0] = (k == 3);
            #1;
            total_cnt++;
            if ({owner, ack} !== {2'd0, 4'b0001}) $display("FAIL stall_resume%0d: got owner=%0d ack=%b expected 0 0001", k, owner, ack);
            else pass_cnt++;
            tick();
        end
        req[0]  = 1'b0;
        last[0] = 1'b0;
        #1;
        total_cnt++;
        if ({busy, ack} !== 5'b0) $display("FAIL stall_gap: got busy=%b ack=%b expected 0 0000", busy, ack);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if ({owner, ack, fifo_w_data} !== {2'd3, 4'b1000, 8'h3C})
            $display("FAIL stall_next: got owner=%0d ack=%b data=%h expected 3 1000 3c", owner, ack, fifo_w_data);
        else pass_cnt++;
        tick();
        req  = '0;
        last = '0;
        for (int i = 0; i < 5; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            total_cnt++;
            if (g !== exp[i]) $display("FAIL stall_fifo%0d: got %h expected %h", i, g, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun();
        logic [B-1:0] g;
        apply_reset();
        req[1] = 1'b1;
        din[1] = 8'h10;
        tick();
        for (int k = 0; k < 4; k++) begin
            din[1] = 8'(8'h10 + k);
            #1;
            total_cnt++;
            if ({ack4, overrun4} !== {4'b0010, 1'b0}) $display("FAIL ovr_beat%0d: got ack=%b ovr=%b expected 0010 0", k, ack4, overrun4);
            else pass_cnt++;
            tick();
        end
        din[1] = 8'h14;
        #1;
        total_cnt++;
        if ({overrun4, busy4, ack4} !== {1'b1, 1'b0, 4'b0000})
            $display("FAIL ovr_pulse: got ovr=%b busy=%b ack=%b expected 1 0 0000", overrun4, busy4, ack4);
        else pass_cnt++;
        total_cnt++;
        if (dut4.ptr_q !== 2'd2) $display("FAIL ovr_ptr: got %0d expected 2", dut4.ptr_q);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({overrun4, busy4, owner4, ack4} !== {1'b0, 1'b1, 2'd1, 4'b0010})
            $display("FAIL ovr_regrant: got ovr=%b busy=%b owner=%0d ack=%b expected 0 1 1 0010", overrun4, busy4, owner4, ack4);
        else pass_cnt++;
        tick();
        din[1]  = 8'h15;
        last[1] = 1'b1;
        #1;
        total_cnt++;
        if (ack4 !== 4'b0010) $display("FAIL ovr_tail: got ack=%b expected 0010", ack4);
        else pass_cnt++;
        tick();
        req  = '0;
        last = '0;
        #1;
        total_cnt++;
        if ({busy4, overrun4} !== 2'b00) $display("FAIL ovr_done: got busy=%b ovr=%b expected 0 0", busy4, overrun4);
        else pass_cnt++;
        total_cnt++;
        if (got4_q.size() !== 6) $display("FAIL ovr_count: got %0d expected 6", got4_q.size());
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            g = (i < got4_q.size()) ? got4_q[i] : 8'hxx;
            total_cnt++;
            if (g !== 8'(8'h10 + i)) $display("FAIL ovr_fifo%0d: got %h expected %h", i, g, 8'(8'h10 + i));
            else pass_cnt++;
        end
    endtask

    task automatic test_boundary();
        apply_reset();
        req[2] = 1'b1;
        din[2] = 8'h40;
        tick();
        for (int k = 0; k < 4; k++) begin
            din[2]  = 8'(8'h40 + k);
            last[2] = (k == 3);
            #1;
            total_cnt++;
            if ({ack4, overrun4} !== {4'b0100, 1'b0}) $display("FAIL bnd_beat%0d: got ack=%b ovr=%b expected 0100 0", k, ack4, overrun4);
            else pass_cnt++;
            tick();
        end
        req  = '0;
        last = '0;
        #1;
        total_cnt++;
        if ({overrun4, busy4, dut4.cnt_q} !== 10'b0)
            $display("FAIL bnd_release: got ovr=%b busy=%b cnt=%0d expected 0 0 0", overrun4, busy4, dut4.cnt_q);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (overrun4 !== 1'b0) $display("FAIL bnd_no_overrun: got %b expected 0", overrun4);
        else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_overrun();
        test_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
